// File: rtl/apple2_video_pkg.sv
// Shared types and constants for the Apple //e video shifter slice:
// display modes, fetch slots, character ROM address layout and dot-slot widths.
package apple2_video_pkg;

  typedef enum logic [2:0] {
    MODE_TEXT40,
    MODE_TEXT80,
    MODE_LORES,
    MODE_HIRES,
    MODE_DHIRES
  } video_mode_e;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_AUX,
    FETCH_MAIN
  } fetch_state_e;

  localparam int unsigned CHAR_ADDR_W   = 12;
  localparam int unsigned CHAR_ROW_W    = 3;
  localparam int unsigned CHAR_BYTE_LSB = 3;
  localparam int unsigned CHAR_ALT_BIT  = 11;

  localparam int unsigned DOTS_NARROW = 7;
  localparam int unsigned DOTS_WIDE   = 14;

  // {ALTCHAR, byte[7:0], row[2:0]}
  function automatic logic [CHAR_ADDR_W-1:0] char_addr(input logic alt,
                                                       input logic [7:0] code,
                                                       input logic [CHAR_ROW_W-1:0] row);
    logic [CHAR_ADDR_W-1:0] a;
    a                      = '0;
    a[CHAR_ALT_BIT]        = alt;
    a[CHAR_BYTE_LSB +: 8]  = code;
    a[CHAR_ROW_W-1:0]      = row;
    return a;
  endfunction

endpackage

// File: rtl/apple2e_video_shifter_serializer.sv
// 14-bit dot serializer: parallel load, shift toward bit0 with zero fill,
// shift rate (every clock or on the slow tick) captured at load time.
module video_serializer
  import apple2_video_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 fast,
  input  logic                 slow_tick,
  input  logic [DOTS_WIDE-1:0] load_data,
  output logic                 dot
);

  logic [DOTS_WIDE-1:0] sr;
  logic                 fast_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      fast_q <= 1'b0;
      dot    <= 1'b0;
    end else begin
      dot <= sr[0];
      if (load) begin
        sr     <= load_data;
        fast_q <= fast;
      end else if (fast_q || slow_tick) begin
        sr <= {1'b0, sr[DOTS_WIDE-1:1]};
      end
    end
  end

endmodule

// File: rtl/apple2e_video_shifter.sv
// Apple //e video shifter: latches fetched RAM bytes, sequences the character
// ROM lookups, decodes the display mode at load and feeds the dot serializer.
module apple2e_video_shifter
  import apple2_video_pkg::*;
#(
  parameter int unsigned FLASH_BITS = 5
) (
  input  logic                   CLK_14M,
  input  logic                   RESET_N,
  input  logic                   LDPS_N,
  input  logic                   VID7M,
  input  logic                   VID_DATA_STB,
  input  logic [7:0]             DATA_MAIN,
  input  logic [7:0]             DATA_AUX,
  input  logic                   SEGA,
  input  logic                   SEGB,
  input  logic                   SEGC,
  input  logic                   GR2,
  input  logic                   HIRES_MODE,
  input  logic                   COL80,
  input  logic                   DHIRES_MODE,
  input  logic                   ALTCHAR,
  input  logic                   WNDW_N,
  input  logic                   VBLANK,
  output logic [CHAR_ADDR_W-1:0] CHAR_ADDR,
  input  logic [7:0]             CHAR_DATA,
  output logic                   VIDEO
);

  logic [7:0]             main_q, aux_q;
  logic [DOTS_NARROW-1:0] main_dots, aux_dots;
  fetch_state_e           state, state_nxt, rom_slot_q;
  logic [FLASH_BITS-1:0]  flash_cnt;
  logic                   vblank_q, vid7m_q;
  video_mode_e            mode;
  logic [DOTS_WIDE-1:0]   load_pat;
  logic                   fast;
  logic                   rom_bit7_unused;

  assign rom_bit7_unused = CHAR_DATA[7];

  // rom_slot_q remembers which byte's address the ROM saw last cycle,
  // so its registered output is steered to the matching dot register.
  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= FETCH_IDLE;
      rom_slot_q <= FETCH_IDLE;
      main_q     <= '0;
      aux_q      <= '0;
      main_dots  <= '0;
      aux_dots   <= '0;
      flash_cnt  <= '0;
      vblank_q   <= 1'b0;
      vid7m_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rom_slot_q <= state;
      vblank_q   <= VBLANK;
      vid7m_q    <= VID7M;
      if (VID_DATA_STB) begin
        main_q <= DATA_MAIN;
        aux_q  <= DATA_AUX;
      end
      if (VBLANK && !vblank_q)
        flash_cnt <= flash_cnt + FLASH_BITS'(1);
      case (rom_slot_q)
        FETCH_AUX:  aux_dots  <= CHAR_DATA[DOTS_NARROW-1:0];
        FETCH_MAIN: main_dots <= CHAR_DATA[DOTS_NARROW-1:0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    state_nxt = FETCH_IDLE;
    CHAR_ADDR = '0;
    case (state)
      FETCH_AUX: begin
        CHAR_ADDR = char_addr(ALTCHAR, aux_q, {SEGC, SEGB, SEGA});
        state_nxt = FETCH_MAIN;
      end
      FETCH_MAIN: begin
        CHAR_ADDR = char_addr(ALTCHAR, main_q, {SEGC, SEGB, SEGA});
        state_nxt = FETCH_IDLE;
      end
      default: state_nxt = FETCH_IDLE;
    endcase
    if (VID_DATA_STB)
      state_nxt = FETCH_AUX;
  end

  always_comb begin
    mode = MODE_TEXT40;
    if (GR2 && HIRES_MODE && DHIRES_MODE && COL80) mode = MODE_DHIRES;
    else if (GR2 && HIRES_MODE)                    mode = MODE_HIRES;
    else if (GR2)                                  mode = MODE_LORES;
    else if (COL80)                                mode = MODE_TEXT80;
  end

  always_comb begin
    logic [3:0]             nib;
    logic [DOTS_WIDE-1:0]   lores_base, lores_pat;
    logic                   flash_on;
    logic [DOTS_NARROW-1:0] glyph_main, glyph_aux;

    nib        = SEGC ? main_q[7:4] : main_q[3:0];
    lores_base = '0;
    for (int unsigned i = 0; i < DOTS_WIDE; i++)
      lores_base[i] = nib[i[1:0]];
    lores_pat  = SEGA ? {lores_base[DOTS_WIDE-3:0], lores_base[DOTS_WIDE-1:DOTS_WIDE-2]}
                      : lores_base;

    // flash_cnt is read before any same-edge VBLANK increment lands
    flash_on   = flash_cnt[FLASH_BITS-1] && !ALTCHAR;
    glyph_main = main_dots ^ {DOTS_NARROW{flash_on && (main_q[7:6] == 2'b01)}};
    glyph_aux  = aux_dots  ^ {DOTS_NARROW{flash_on && (aux_q[7:6]  == 2'b01)}};

    fast     = 1'b1;
    load_pat = '0;
    case (mode)
      MODE_DHIRES: load_pat = {main_q[DOTS_NARROW-1:0], aux_q[DOTS_NARROW-1:0]};
      MODE_HIRES: begin
        load_pat = {{DOTS_NARROW{1'b0}}, main_q[DOTS_NARROW-1:0]};
        fast     = 1'b0;
      end
      MODE_LORES:  load_pat = lores_pat;
      MODE_TEXT80: load_pat = {glyph_main, glyph_aux};
      default: begin
        load_pat = {{DOTS_NARROW{1'b0}}, glyph_main};
        fast     = 1'b0;
      end
    endcase
    if (WNDW_N)
      load_pat = '0;
  end

  video_serializer u_serializer (
    .clk       (CLK_14M),
    .rst_n     (RESET_N),
    .load      (!LDPS_N),
    .fast      (fast),
    .slow_tick (VID7M && !vid7m_q),
    .load_data (load_pat),
    .dot       (VIDEO)
  );

endmodule
